nios2_system_key_ctrl: RTL and testbench

Avalon-MM slave controller for the board push-buttons. It synchronises and debounces each active-low key, keeps a debounced level register, and captures press edges into sticky bits with a per-bit interrupt mask. It drives a level-sensitive IRQ to the Nios II. It sits between the raw `in_port` pins and the system interconnect, replacing the bare key input port.

---
 rtl/nios2_system_key_pkg.sv | 19 +
 rtl/nios2_system_key_ctrl_if.sv | 29 ++
 rtl/nios2_system_key_debounce.sv | 94 +++++++++
 rtl/nios2_system_key_ctrl.sv | 113 +++++++++++
 tb/tb_nios2_system_key_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/nios2_system_key_pkg.sv
// -----------------------------------------------------------------------------
// nios2_system_key_pkg
// Shared constants for the push-button controller. These are the Avalon word
// addresses of the four registers, the default counter width and the reset
// value of the debounce period.
// -----------------------------------------------------------------------------
package nios2_system_key_pkg;

  localparam int CNT_W            = 20;
  localparam int DEBOUNCE_DEFAULT = 50000;  // 1 ms at 50 MHz

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,  // RO : debounced key level
    ADDR_PERIOD = 2'd1,  // RW : debounce period in clk cycles
    ADDR_MASK   = 2'd2,  // RW : interrupt mask
    ADDR_EDGE   = 2'd3   // W1C: press-capture bits
  } key_addr_e;

endpackage

// File: rtl/nios2_system_key_ctrl_if.sv
// -----------------------------------------------------------------------------
// nios2_system_key_ctrl_if
// Avalon-MM slave bus bundle for the key controller.
//   address    : word address (2 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe, valid with chipselect
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (driven by the slave)
// master drives the request side. slave drives readdata.
// -----------------------------------------------------------------------------
interface nios2_system_key_ctrl_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/nios2_system_key_debounce.sv
// -----------------------------------------------------------------------------
// nios2_system_key_debounce
// One key's two-flop synchroniser, debounce counter and debounced level flop.
// The build option is NIOS2_SYSTEM_KEY_DEBOUNCE_EN.
//   clk, reset_n : clock, asynchronous active-low reset
//   key_n        : raw asynchronous key pin, active-low
//   period       : debounce period P; present only when debouncing is built.
//                  P=0 acts as P=1.
//   stable       : debounced level (resets to 1, i.e. released)
//   press        : one-cycle pulse in the cycle after stable falls 1->0
// When NIOS2_SYSTEM_KEY_DEBOUNCE_EN is undefined there is no counter.
// stable simply follows the synchroniser output one flop later. This gives
// the same timing as P=1.
// -----------------------------------------------------------------------------
module nios2_system_key_debounce #(
  parameter int CNT_W = nios2_system_key_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_n,
`ifdef NIOS2_SYSTEM_KEY_DEBOUNCE_EN
  input  logic [CNT_W-1:0] period,
`endif
  output logic             stable,
  output logic             press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic stable_q, stable_d;
  logic press_q, press_d;

`ifdef NIOS2_SYSTEM_KEY_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] peff_m1;

  // The compare uses the live period, so a counter that is already past a
  // newly lowered value commits on the next edge.
  assign peff_m1 = (period == '0) ? '0 : period - 1'b1;

  // NOTE: every signal written here gets a default first. A path that leaves a
  //       combinational output unassigned would infer a latch.
  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;                   // agreement (or a bounce back) restarts
    end else if (cnt_q >= peff_m1) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      press_d  = ~sync2_q;          // only the 1->0 commit is a press
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    stable_d = sync2_q;
    press_d  = stable_q & ~sync2_q;
  end
`endif

  // NOTE: state flops use non-blocking assignments so that every flop samples
  //       the values from before the edge, whatever order the blocks run in.
  //       Synchroniser and level reset to 1 (released), so no spurious press
  //       follows reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/nios2_system_key_ctrl.sv
// -----------------------------------------------------------------------------
// nios2_system_key_ctrl
// Avalon-MM push-button controller. It debounces each active-low key, holds
// the debounced level, captures presses into sticky W1C bits and drives a
// level IRQ.
// The build option is NIOS2_SYSTEM_KEY_DEBOUNCE_EN. When it is defined, the
// debounce counters and the PERIOD register are built. Otherwise PERIOD reads
// 0 and writes to it are ignored.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port      : raw key pins, active-low
//   irq          : |(edge & mask), active-high level
// Register map: 0 DATA (RO), 1 PERIOD (RW), 2 MASK (RW), 3 EDGE (W1C).
// Reads are registered every edge from address, whether or not chipselect is
// asserted.
// -----------------------------------------------------------------------------
module nios2_system_key_ctrl #(
  parameter int WIDTH            = 4,
  parameter int DEBOUNCE_DEFAULT = nios2_system_key_pkg::DEBOUNCE_DEFAULT,
  parameter int CNT_W            = nios2_system_key_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  nios2_system_key_ctrl_if.slave   bus,
  input  logic [WIDTH-1:0]         in_port,
  output logic                     irq
);

  import nios2_system_key_pkg::*;

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  key_addr_e        addr;
  logic             unused_wdata;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign addr  = key_addr_e'(bus.address);

`ifdef NIOS2_SYSTEM_KEY_DEBOUNCE_EN
  logic [CNT_W-1:0] period_q, period_d;

  always_comb begin
    period_d = period_q;
    if (wr_en && addr == ADDR_PERIOD) period_d = bus.writedata[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) period_q <= CNT_W'(DEBOUNCE_DEFAULT);
    else          period_q <= period_d;
  end

  assign unused_wdata = ^bus.writedata[31:CNT_W];
`else
  assign unused_wdata = ^bus.writedata[31:WIDTH];
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    nios2_system_key_debounce #(.CNT_W(CNT_W)) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .key_n   (in_port[i]),
`ifdef NIOS2_SYSTEM_KEY_DEBOUNCE_EN
      .period  (period_q),
`endif
      .stable  (stable[i]),
      .press   (press[i])
    );
  end

  always_comb begin
    mask_d   = mask_q;
    edge_clr = '0;
    if (wr_en && addr == ADDR_MASK) mask_d   = bus.writedata[WIDTH-1:0];
    if (wr_en && addr == ADDR_EDGE) edge_clr = bus.writedata[WIDTH-1:0];
    // Clear first, then set: a press in the same cycle as its W1C survives.
    edge_d = (edge_q & ~edge_clr) | press;

    readdata_d = '0;
    unique case (addr)
      ADDR_DATA:   readdata_d[WIDTH-1:0] = stable;
`ifdef NIOS2_SYSTEM_KEY_DEBOUNCE_EN
      ADDR_PERIOD: readdata_d[CNT_W-1:0] = period_q;
`else
      ADDR_PERIOD: readdata_d = '0;
`endif
      ADDR_MASK:   readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE:   readdata_d[WIDTH-1:0] = edge_q;
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  // The IRQ is a function of flops only. There is no path from the bus inputs.
  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_nios2_system_key_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nios2_system_key_ctrl
// Directed bench for nios2_system_key_ctrl. Expected values are computed by
// hand from the register map and the press-latency rule (stable at k+1+Peff,
// EDGE/irq at k+2+Peff). It covers both settings of
// NIOS2_SYSTEM_KEY_DEBOUNCE_EN. Without debouncing, Peff is 1 and PERIOD
// reads 0.
// -----------------------------------------------------------------------------
module tb_nios2_system_key_ctrl;

  import nios2_system_key_pkg::*;

`ifdef NIOS2_SYSTEM_KEY_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_port;
  logic       irq;
  int         n_cmp = 0;
  int         n_bad = 0;

  nios2_system_key_ctrl_if bus ();

  nios2_system_key_ctrl #(
    .WIDTH(4), .DEBOUNCE_DEFAULT(50000), .CNT_W(20)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  function automatic int peff(int p);
    if (!DEB) return 1;
    return (p < 1) ? 1 : p;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input key_addr_e a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic read_check(input key_addr_e a, input string tag, input logic [31:0] exp);
    bus.address = a;
    tick();
    check(tag, bus.readdata, exp);
  endtask

  // Drive a press and report the edge index (k = 0) at which irq first rises.
  task automatic measure_press(input logic [3:0] pins, output int lat);
    in_port = pins;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (irq) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int lat;
    reset_n        = 1'b0;
    in_port        = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    ticks(3);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", irq, 1'b0);
    reset_n = 1'b1;
    ticks(2);

    read_check(ADDR_DATA,   "rst_data",   32'hF);
    read_check(ADDR_PERIOD, "rst_period", DEB ? 32'd50000 : 32'd0);
    read_check(ADDR_MASK,   "rst_mask",   32'h0);
    read_check(ADDR_EDGE,   "rst_edge",   32'h0);
    bus_write(ADDR_DATA, 32'h0);
    read_check(ADDR_DATA,   "data_ro",    32'hF);

    // Clean press of key 0 with PERIOD=4.
    bus_write(ADDR_PERIOD, 32'd4);
    bus_write(ADDR_MASK,   32'h1);
    read_check(ADDR_PERIOD, "period_rw", DEB ? 32'd4 : 32'd0);
    p = peff(4);
    bus.address = ADDR_DATA;
    in_port = 4'hE;
    for (int n = 0; n <= 2 + p; n++) begin
      tick();
      if (n == 1 + p) begin
        check("press_data_early", bus.readdata, 32'hF);
        check("press_irq_early",  irq, 1'b0);
      end
      if (n == 2 + p) begin
        check("press_data", bus.readdata, 32'hE);
        check("press_irq",  irq, 1'b1);
      end
    end
    read_check(ADDR_EDGE, "press_edge", 32'h1);
    in_port = 4'hF;
    ticks(p + 4);
    read_check(ADDR_EDGE, "release_edge", 32'h1);
    bus_write(ADDR_EDGE, 32'h1);
    check("w1c_irq_low", irq, 1'b0);
    read_check(ADDR_EDGE, "w1c_edge", 32'h0);

    // Bounce: key 1 low for 3 cycles, one short of PERIOD=4.
    bus_write(ADDR_MASK, 32'h2);
    in_port = 4'hD;
    ticks(3);
    in_port = 4'hF;
    ticks(8);
    read_check(ADDR_DATA, "bounce_data", 32'hF);
    read_check(ADDR_EDGE, "bounce_edge", DEB ? 32'h0 : 32'h2);
    check("bounce_irq", irq, DEB ? 1'b0 : 1'b1);
    bus_write(ADDR_EDGE, 32'h2);
    bus_write(ADDR_MASK, 32'h0);

    // W1C, then a clear that lands on the same edge as a key-2 set.
    in_port = 4'hC;
    ticks(p + 4);
    in_port = 4'hF;
    ticks(p + 4);
    read_check(ADDR_EDGE, "edge_two_keys", 32'h3);
    bus_write(ADDR_EDGE, 32'h1);
    read_check(ADDR_EDGE, "w1c_partial", 32'h2);
    in_port = 4'hB;
    ticks(2 + p);
    bus_write(ADDR_EDGE, 32'h4);
    read_check(ADDR_EDGE, "set_beats_clr", 32'h6);
    in_port = 4'hF;
    ticks(p + 4);
    bus_write(ADDR_EDGE, 32'h6);
    read_check(ADDR_EDGE, "edge_cleared", 32'h0);

    // Mask gating with key 3.
    in_port = 4'h7;
    ticks(p + 4);
    read_check(ADDR_EDGE, "masked_edge", 32'h8);
    check("masked_irq", irq, 1'b0);
    bus_write(ADDR_MASK, 32'h8);
    check("unmask_irq", irq, 1'b1);
    in_port = 4'hF;
    ticks(p + 4);
    read_check(ADDR_EDGE, "release_no_set", 32'h8);
    bus_write(ADDR_EDGE, 32'h8);
    check("clear_irq", irq, 1'b0);

    // PERIOD=0 must behave as PERIOD=1.
    bus_write(ADDR_MASK, 32'h1);
    bus_write(ADDR_PERIOD, 32'd0);
    read_check(ADDR_PERIOD, "period_zero", 32'd0);
    measure_press(4'hE, lat);
    check("p0_latency", lat, 2 + peff(0));
    in_port = 4'hF;
    ticks(6);
    bus_write(ADDR_EDGE, 32'h1);
    bus_write(ADDR_PERIOD, 32'd1);
    read_check(ADDR_PERIOD, "period_one", DEB ? 32'd1 : 32'd0);
    measure_press(4'hE, lat);
    check("p1_latency", lat, 2 + peff(1));
    in_port = 4'hF;
    ticks(6);
    bus_write(ADDR_EDGE, 32'h1);

    // Lower PERIOD 100 -> 2 while key 1's counter is at 10.
    bus_write(ADDR_MASK, 32'h2);
    bus_write(ADDR_PERIOD, 32'd100);
    in_port = 4'hD;
    ticks(12);                        // just after edge k+11, cnt == 10
    bus_write(ADDR_PERIOD, 32'd2);    // edge k+12
    bus.address = ADDR_DATA;
    tick();                           // edge k+13: stable commits
    check("lower_irq_wait", irq, DEB ? 1'b0 : 1'b1);
    check("lower_data_wait", bus.readdata, DEB ? 32'hF : 32'hD);
    tick();                           // edge k+14
    check("lower_data", bus.readdata, 32'hD);
    check("lower_irq", irq, 1'b1);

    // Reset mid-count with an irq pending.
    in_port = 4'hC;
    ticks(2);
    reset_n = 1'b0;
    in_port = 4'hF;
    #1;
    check("async_rst_irq", irq, 1'b0);
    check("async_rst_readdata", bus.readdata, 32'h0);
    ticks(3);
    reset_n = 1'b1;
    ticks(10);
    read_check(ADDR_DATA,   "rerst_data",   32'hF);
    read_check(ADDR_PERIOD, "rerst_period", DEB ? 32'd50000 : 32'd0);
    read_check(ADDR_MASK,   "rerst_mask",   32'h0);
    read_check(ADDR_EDGE,   "rerst_edge",   32'h0);
    check("rerst_irq", irq, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
